// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared register-file defaults and register index constants.
package regfile_scoreboard_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero-register masking,
// write bypass and busy lookup.
module regfile_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy_vec,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy
);
    logic w_zero, w_byp;
    assign w_zero  = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));
    assign w_byp   = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    assign rd_data = w_zero ? '0 : w_byp ? wr_data : mem[rd_addr];
    assign busy    = w_zero ? 1'b0 : w_byp ? 1'b0 : busy_vec[rd_addr];
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with bypass and a per-register busy
// scoreboard for RAW hazard detection between decode and writeback.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_stall,
    output logic [ADDR_W:0]   busy_count
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy, w_busy_nxt;
    logic [ADDR_W:0]   r_busy_count, w_count_nxt;
    logic              w_wr_ok, w_claim_ok;
    // a write in the same cycle releases the register, so the claim may proceed
    assign claim_stall = claim_en & r_busy[claim_addr] & ~(wr_en & (wr_addr == claim_addr));
    assign w_wr_ok     = wr_en & ~((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
    assign w_claim_ok  = claim_en & ~claim_stall & ~((ZERO_REG != 0) && (claim_addr == ADDR_W'(REG_ZERO)));
    assign busy_count  = r_busy_count;
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) w_busy_nxt[wr_addr] = 1'b0;
        if (w_claim_ok) w_busy_nxt[claim_addr] = 1'b1;
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem        <= '{default: '0};
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok) r_mem[wr_addr] <= wr_data;
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_a (
        .rd_addr(rd_addr_a), .mem(r_mem), .busy_vec(r_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_data(rd_data_a), .busy(busy_a)
    );
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_b (
        .rd_addr(rd_addr_b), .mem(r_mem), .busy_vec(r_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_data(rd_data_b), .busy(busy_b)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: drives two configurations (ZERO_REG=0/BYPASS=1 and
// ZERO_REG=1/BYPASS=0) with shared stimulus and scores them against a model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, we, ce;
    logic [3:0] ra, rb, wa, ca;
    logic [15:0] wd;
    logic [15:0] rda [2];
    logic [15:0] rdb [2];
    logic ba [2];
    logic bb [2];
    logic st [2];
    logic [4:0] cnt [2];
    int n_chk = 0;
    int n_pass = 0;
    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .reset(rst), .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda[0]), .rd_data_b(rdb[0]),
        .busy_a(ba[0]), .busy_b(bb[0]), .wr_en(we), .wr_addr(wa), .wr_data(wd), .claim_en(ce),
        .claim_addr(ca), .claim_stall(st[0]), .busy_count(cnt[0])
    );
    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(rst), .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda[1]), .rd_data_b(rdb[1]),
        .busy_a(ba[1]), .busy_b(bb[1]), .wr_en(we), .wr_addr(wa), .wr_data(wd), .claim_en(ce),
        .claim_addr(ca), .claim_stall(st[1]), .busy_count(cnt[1])
    );
    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic        ba;
        logic        bb;
        logic        st;
        logic [4:0]  cnt;
    } exp_t;
    exp_t q[$];
    logic [15:0] m [2][16];
    logic        bz [2][16];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    function automatic exp_t predict(input int k);
        exp_t e;
        bit zr = (k == 1);
        bit bp = (k == 0);
        bit za = zr && ra == 0;
        bit zb = zr && rb == 0;
        bit ha = bp && we && wa == ra;
        bit hb = bp && we && wa == rb;
        e.k   = k;
        e.a   = za ? 16'h0 : ha ? wd : m[k][ra];
        e.b   = zb ? 16'h0 : hb ? wd : m[k][rb];
        e.ba  = za ? 1'b0 : ha ? 1'b0 : bz[k][ra];
        e.bb  = zb ? 1'b0 : hb ? 1'b0 : bz[k][rb];
        e.st  = ce && bz[k][ca] && !(we && wa == ca);
        e.cnt = 0;
        for (int i = 0; i < 16; i++) e.cnt += 5'(bz[k][i]);
        return e;
    endfunction
    task automatic model_edge(input int k);
        bit zr = (k == 1);
        bit stall = ce && bz[k][ca] && !(we && wa == ca);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m[k][i]  = 16'h0;
                bz[k][i] = 1'b0;
            end
        end else begin
            if (we && !(zr && wa == 0)) begin
                m[k][wa]  = wd;
                bz[k][wa] = 1'b0;
            end
            if (ce && !stall && !(zr && ca == 0)) bz[k][ca] = 1'b1;
        end
    endtask
    task automatic step(input logic r, input logic [3:0] a_, input logic [3:0] b_, input logic w,
                        input logic [3:0] wa_, input logic [15:0] wd_, input logic c, input logic [3:0] ca_);
        exp_t e;
        @(negedge clk);
        rst = r; ra = a_; rb = b_; we = w; wa = wa_; wd = wd_; ce = c; ca = ca_;
        q.push_back(predict(0));
        q.push_back(predict(1));
        #2;
        repeat (2) begin
            e = q.pop_front();
            chk($sformatf("rd_a%0d", e.k), 32'(rda[e.k]), 32'(e.a));
            chk($sformatf("rd_b%0d", e.k), 32'(rdb[e.k]), 32'(e.b));
            chk($sformatf("busy_a%0d", e.k), 32'(ba[e.k]), 32'(e.ba));
            chk($sformatf("busy_b%0d", e.k), 32'(bb[e.k]), 32'(e.bb));
            chk($sformatf("stall%0d", e.k), 32'(st[e.k]), 32'(e.st));
            chk($sformatf("count%0d", e.k), 32'(cnt[e.k]), 32'(e.cnt));
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
    endtask
    initial begin
        rst = 1'b1; ra = 0; rb = 0; we = 0; wa = 0; wd = 0; ce = 0; ca = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                m[k][i]  = 16'h0;
                bz[k][i] = 1'b0;
            end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(cnt[0]), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 4'(i), 4'(15 - i), 0, 0, 0, 0, 0);
        step(0, 5, 5, 1, 5, 16'hBEEF, 0, 0);
        step(0, 5, 0, 0, 0, 0, 0, 0);
        #1 chk("beef_a", 32'(rda[0]), 32'hBEEF);
        step(0, 3, 3, 0, 0, 0, 1, 3);
        step(0, 3, 3, 0, 0, 0, 1, 3);
        step(0, 3, 3, 1, 3, 16'h1234, 0, 0);
        step(0, 3, 3, 0, 0, 0, 0, 0);
        #1 chk("r3_data", 32'(rda[0]), 32'h1234);
        chk("r3_count", 32'(cnt[0]), 32'd0);
        step(0, 7, 7, 0, 0, 0, 1, 7);
        step(0, 7, 7, 1, 7, 16'h5A5A, 1, 7);
        step(0, 7, 7, 0, 0, 0, 0, 0);
        #1 chk("r7_busy", 32'(ba[0]), 32'd1);
        chk("r7_count", 32'(cnt[0]), 32'd1);
        step(0, 7, 7, 1, 7, 16'h0007, 0, 0);
        step(0, 0, 0, 1, 0, 16'hFFFF, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("z_rd", 32'(rda[1]), 32'd0);
        chk("z_busy", 32'(ba[1]), 32'd0);
        chk("z_count", 32'(cnt[1]), 32'd0);
        step(0, 0, 0, 1, 0, 16'h0, 0, 0);
        step(0, 1, 2, 0, 0, 0, 1, 1);
        step(0, 1, 2, 0, 0, 0, 1, 2);
        step(0, 4, 2, 0, 0, 0, 1, 4);
        step(1, 2, 5, 1, 2, 16'hAAAA, 1, 6);
        step(0, 2, 5, 0, 0, 0, 0, 0);
        #1 chk("rst2_data", 32'(rdb[0]), 32'd0);
        chk("rst2_count", 32'(cnt[0]), 32'd0);
        chk("rst2_busy", 32'(ba[0]), 32'd0);
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 40) == 0, 4'($urandom), 4'($urandom), 1'($urandom),
                 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
